adder_arbiter: RTL

Shares a single combinational 8-bit `adder_gate` instance among `N_REQ` requesters. Per-requester valid/ready handshakes on both request and response. Arbitration is round-robin or fixed priority. Operands are registered before the adder and the 9-bit `{carry, sum}` is registered after it, so the ripple path gets one full cycle (7.0 ns target).

---
 rtl/adder_arb_pkg.sv | 13 +
 rtl/adder_arbiter_if.sv | 28 ++
 rtl/adder_arbiter_rr_picker.sv | 30 +++
 rtl/adder_gate.sv | 11 +
 rtl/adder_arbiter.sv | 104 ++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and widths for the adder_arbiter block: FSM encoding and datapath widths.
package adder_arb_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADD  = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between N_REQ requesters (master) and the shared adder arbiter (slave).
interface adder_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int OWN_W = 2
);
    import adder_arb_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*OP_W-1:0] req_x;
    logic [N_REQ*OP_W-1:0] req_y;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [RES_W-1:0]      rsp_data;
    logic                  busy;
    logic [OWN_W-1:0]      owner;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy, owner
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy, owner
    );

endinterface

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational picker: first asserted request at or after ptr, wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int OWN_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [OWN_W-1:0] idx
);

    always_comb begin
        logic found;
        int   pos;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            if (!found && req[pos[OWN_W-1:0]]) begin
                found                = 1'b1;
                gnt[pos[OWN_W-1:0]]  = 1'b1;
                idx                  = pos[OWN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_gate.sv
// Plain combinational 8-bit ripple adder with carry out and no carry in.
module adder_gate (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic       carry,
    output logic [7:0] out
);

    assign {carry, out} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered-in/registered-out 8-bit adder among N_REQ requesters.
// Define ADDER_ARB_RR_EN for round-robin; default build is fixed priority (lowest index wins).
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int OWN_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);

    state_t           state, state_nx;
    logic [N_REQ-1:0] gnt;
    logic [OWN_W-1:0] pick_idx;
    logic [OWN_W-1:0] ptr;
    logic [OWN_W-1:0] owner_r;
    logic [OP_W-1:0]  x_p0, y_p0;
    logic [RES_W-1:0] res_p1;
    logic             add_carry;
    logic [OP_W-1:0]  add_sum;

`ifdef ADDER_ARB_RR_EN
    logic [OWN_W-1:0] ptr_r;

    // Pointer moves past the owner only once its response has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (state == S_RESP && bus.rsp_ready[owner_r]) begin
            if (owner_r == OWN_W'(N_REQ - 1)) ptr_r <= '0;
            else                              ptr_r <= owner_r + 1'b1;
        end
    end

    assign ptr = ptr_r;
`else
    assign ptr = '0;
`endif

    rr_picker #(.N_REQ(N_REQ), .OWN_W(OWN_W)) u_picker (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (pick_idx)
    );

    adder_gate u_adder (
        .x     (x_p0),
        .y     (y_p0),
        .carry (add_carry),
        .out   (add_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            owner_r <= '0;
            x_p0    <= '0;
            y_p0    <= '0;
            res_p1  <= '0;
        end else begin
            state <= state_nx;
            // p0: operand capture at the grant edge
            if (state == S_IDLE && |bus.req_valid) begin
                x_p0    <= bus.req_x[pick_idx*OP_W +: OP_W];
                y_p0    <= bus.req_y[pick_idx*OP_W +: OP_W];
                owner_r <= pick_idx;
            end
            // p1: adder result capture, gives the ripple path a full cycle
            if (state == S_ADD) begin
                res_p1 <= {add_carry, add_sum};
            end
        end
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        case (state)
            S_IDLE: begin
                bus.req_ready = gnt;
                if (|bus.req_valid) state_nx = S_ADD;
            end
            S_ADD: begin
                state_nx = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid[owner_r] = 1'b1;
                if (bus.rsp_ready[owner_r]) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.rsp_data = res_p1;
    assign bus.busy     = (state != S_IDLE);
    assign bus.owner    = owner_r;

endmodule
